// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional build macro used by this family: CLOCK_DIV_ODD_DUTY50_EN.
package clock_div_pkg;

    // IDLE: stopped, RUN: counting, DRAIN: finishing the current period after en fell
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } div_state_t;

    // Smallest divisor that still yields a real high and low phase
    localparam int unsigned DIV_MIN = 2;

    // Raise any divisor below DIV_MIN up to DIV_MIN
    function automatic logic [31:0] clamp_div(input logic [31:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/clock_div_phase.sv
// Period counter and phase generator for the programmable clock divider.
// With CLOCK_DIV_ODD_DUTY50_EN defined, odd divisors get a falling-edge
// stage that stretches the high phase by half a clk_in period (50% duty).
module clock_div_phase #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,       // a period is in progress in the next cycle
    input  logic [CNT_W-1:0] div_cur,   // divisor of the current cycle
    input  logic [CNT_W-1:0] div_next,  // divisor of the next cycle
    output logic             wrap,      // current cycle is the last one of its period
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] high_len;
    logic             active_reg;
    logic             phase_reg;
    logic             phase_next;
    logic             tick_reg;
    logic             tick_next;

    assign wrap = active_reg && (cnt_reg == div_cur - CNT_ONE);

`ifdef CLOCK_DIV_ODD_DUTY50_EN
    // Rising-edge phase covers floor(N/2) cycles; the negedge stage adds the half cycle
    assign high_len = div_next >> 1;
`else
    // ceil(N/2) written without N+1 so N = 2^CNT_W-1 cannot overflow
    assign high_len = (div_next >> 1) + {{(CNT_W-1){1'b0}}, div_next[0]};
`endif

    // Next count position plus the phase and tick that go with it
    always_comb begin
        cnt_next = '0;
        if (run && active_reg && !wrap) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
        phase_next = run && (cnt_next < high_len);
        tick_next  = run && (cnt_next == '0);
    end

    // Counter and registered outputs; reset aborts the period immediately
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            phase_reg  <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            active_reg <= run;
            phase_reg  <= phase_next;
            tick_reg   <= tick_next;
        end
    end

`ifdef CLOCK_DIV_ODD_DUTY50_EN
    logic neg_reg;

    // Half-cycle delayed copy of the phase, only for odd divisors
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            neg_reg <= 1'b0;
        end else begin
            neg_reg <= div_cur[0] & phase_reg;
        end
    end

    assign clk_out = phase_reg | neg_reg;
`else
    assign clk_out = phase_reg;
`endif

    assign tick = tick_reg;

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable clock divider: run/drain FSM and divisor load/ack
// handshake around the clock_div_phase counter. Divisor changes, start and
// stop only happen on period boundaries so clk_out never glitches.
// Optional macro: CLOCK_DIV_ODD_DUTY50_EN (50% duty for odd divisors).
// CNT_W must not exceed 32 (the shared clamp helper is 32 bits wide).
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick
);

    div_state_t       state_reg;
    div_state_t       state_next;
    logic [CNT_W-1:0] div_cur_reg;
    logic [CNT_W-1:0] div_cur_next;
    logic [CNT_W-1:0] div_pend_reg;
    logic [CNT_W-1:0] div_pend_next;
    logic             pend_reg;
    logic             pend_next;
    logic             div_ack_reg;
    logic [CNT_W-1:0] div_clamped;
    logic             wrap;
    logic             boundary;
    logic             apply;
    logic             run;

    assign div_clamped = CNT_W'(clamp_div(32'(div_val)));

    // Next state: a period, once started, always runs to its wrap
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = wrap ? IDLE : DRAIN;
            DRAIN:   if (en) state_next = RUN;
                     else if (wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pending divisor: applied at a wrap or while idle; a load in the same
    // cycle as an apply waits for the following boundary
    always_comb begin
        boundary      = (state_reg == IDLE) || wrap;
        apply         = pend_reg && boundary;
        div_cur_next  = apply ? div_pend_reg : div_cur_reg;
        pend_next     = pend_reg;
        div_pend_next = div_pend_reg;
        if (div_load) begin
            pend_next     = 1'b1;
            div_pend_next = div_clamped;
        end else if (apply) begin
            pend_next = 1'b0;
        end
    end

    assign run = (state_next != IDLE);

    // FSM and handshake registers; reset drops any pending load
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            div_cur_reg  <= CNT_W'(DEFAULT_DIV);
            div_pend_reg <= '0;
            pend_reg     <= 1'b0;
            div_ack_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cur_reg  <= div_cur_next;
            div_pend_reg <= div_pend_next;
            pend_reg     <= pend_next;
            div_ack_reg  <= apply;
        end
    end

    assign div_ack = div_ack_reg;

    clock_div_phase #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clk_in  (clk_in),
        .rst     (rst),
        .run     (run),
        .div_cur (div_cur_reg),
        .div_next(div_cur_next),
        .wrap    (wrap),
        .clk_out (clk_out),
        .tick    (tick)
    );

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog (default build, odd-duty feature off).
// A period-level model predicts clk_out/tick/div_ack every cycle; directed
// periods with literal lengths pin the model, then random stimulus follows.
module tb_clock_div_prog;

    localparam int CNT_W = 16;
    localparam int DEF   = 10;

    logic             clk_in   = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val  = '0;
    logic             div_ack;
    logic             clk_out;
    logic             tick;

    int total = 0;
    int bad   = 0;

    clock_div_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .div_ack (div_ack),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (period level) ----------------
    bit m_active = 0;   // a period is in progress this cycle
    int m_pos    = 0;   // position inside the period
    int m_n      = DEF; // divisor of this period
    bit m_pend   = 0;
    int m_pval   = 0;
    bit m_ack    = 0;
    bit m_last;
    bit m_bnd;
    int m_nn;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_active = 0; m_pos = 0; m_n = DEF; m_pend = 0; m_pval = 0; m_ack = 0;
        end else begin
            m_last = m_active && (m_pos == m_n - 1);
            m_bnd  = !m_active || m_last;
            m_ack  = m_pend && m_bnd;
            m_nn   = m_ack ? m_pval : m_n;
            if (div_load) begin
                m_pend = 1;
                m_pval = (int'(div_val) < 2) ? 2 : int'(div_val);
            end else if (m_ack) begin
                m_pend = 0;
            end
            if (m_active && !m_last) begin
                m_pos++;
            end else begin
                m_active = en;
                m_pos    = 0;
            end
            m_n = m_nn;
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk_in) begin
        check("clk_out", longint'(clk_out), longint'(m_active && (m_pos < (m_n + 1) / 2)));
        check("tick",    longint'(tick),    longint'(m_active && (m_pos == 0)));
        check("div_ack", longint'(div_ack), longint'(m_ack));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // kind 1: load value, kind 2: drive en to value
    task automatic act(input int kind, input int val);
        if (kind == 1) begin
            div_load = 1'b1;
            div_val  = CNT_W'(val);
        end else if (kind == 2) begin
            en = (val != 0);
        end
    endtask

    // Start in a tick cycle; run until the next tick (or max_len cycles)
    task automatic next_period(input int a_at, input int a_kind, input int a_val,
                               input int b_at, input int b_kind, input int b_val,
                               input int max_len, output int len, output int high);
        len  = 0;
        high = 0;
        do begin
            if (len == a_at) act(a_kind, a_val);
            if (len == b_at) act(b_kind, b_val);
            high += int'(clk_out);
            step();
            div_load = 1'b0;
            len++;
        end while (!tick && len < max_len);
        $display("period: len=%0d high=%0d ack=%0d", len, high, div_ack);
    endtask

    int len;
    int high;

    initial begin
        // Reset state
        step(); step();
        check("rst_clk_out", longint'(clk_out), 0);
        check("rst_tick",    longint'(tick),    0);
        check("rst_div_ack", longint'(div_ack), 0);
        rst = 1'b0;
        step();
        en = 1'b1;
        step();
        check("start_tick",    longint'(tick),    1);
        check("start_clk_out", longint'(clk_out), 1);

        // Default divisor 10: 5 high / 5 low
        next_period(-1, 0, 0, -1, 0, 0, 100, len, high);
        check("def_len", len, 10); check("def_high", high, 5);
        next_period(-1, 0, 0, -1, 0, 0, 100, len, high);
        check("def_len2", len, 10); check("def_high2", high, 5);

        // Load 7 at cnt=3: current period finishes, then 7-cycle periods
        next_period(3, 1, 7, -1, 0, 0, 100, len, high);
        check("load7_len", len, 10); check("load7_ack", longint'(div_ack), 1);
        next_period(-1, 0, 0, -1, 0, 0, 100, len, high);
        check("n7_len", len, 7); check("n7_high", high, 4);
        check("model_n7", m_n, 7);

        // Two loads before the boundary: last wins, one ack
        next_period(1, 1, 6, 2, 1, 4, 100, len, high);
        check("dbl_len", len, 7); check("dbl_ack", longint'(div_ack), 1);
        next_period(-1, 0, 0, -1, 0, 0, 100, len, high);
        check("n4_len", len, 4); check("n4_high", high, 2);
        check("n4_no_ack", longint'(div_ack), 0);

        // Reset mid-high phase with a pending load
        div_load = 1'b1; div_val = CNT_W'(3);
        step();
        div_load = 1'b0;
        check("pre_rst_high", longint'(clk_out), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_clk_out", longint'(clk_out), 0);
        check("arst_tick",    longint'(tick),    0);
        check("arst_div_ack", longint'(div_ack), 0);
        step(); step();
        rst = 1'b0;
        step();
        check("rerun_tick", longint'(tick), 1);
        next_period(-1, 0, 0, -1, 0, 0, 100, len, high);
        check("rerun_len", len, 10); check("rerun_high", high, 5);

        // N=8, en drop at cnt=2 with re-raise during DRAIN: no gap
        next_period(0, 1, 8, -1, 0, 0, 100, len, high);
        check("load8_len", len, 10);
        next_period(2, 2, 0, 5, 2, 1, 100, len, high);
        check("drain_len", len, 8); check("drain_high", high, 4);
        // en drop at cnt=2, no re-raise: period completes then stays low
        next_period(2, 2, 0, -1, 0, 0, 14, len, high);
        check("stop_len", len, 14); check("stop_high", high, 4);
        en = 1'b1;
        step();
        check("restart_tick", longint'(tick), 1);

        // div_val=0 is clamped to 2
        next_period(1, 1, 0, -1, 0, 0, 100, len, high);
        check("load0_len", len, 8);
        next_period(-1, 0, 0, -1, 0, 0, 100, len, high);
        check("n2_len", len, 2); check("n2_high", high, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 99) < 85);
            div_load = ($urandom_range(0, 99) < 6);
            div_val  = CNT_W'($urandom_range(0, 20));
            rst      = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
